data_mem_unit: RTL and testbench
================================

// Module: data_mem_unit
// PURPOSE
//  MEM-stage data memory for the MIPS pipeline. Parametrised in word width, address width and read latency.
//  Supports byte/halfword/word loads and stores, with sign or zero extension and little-endian lane selection.
//  Reads stall the pipeline for a configurable number of wait cycles; misaligned and illegal requests are flagged.
//  Provides a side debug read port for the debug/UART unit.
// PARAMETERS
//  NB_DATA     32  data word width (multiple of 16; byte lanes = NB_DATA/8)
//  NB_ADDR     10  byte-address width; depth = 2**(NB_ADDR-2) words (NB_DATA=32)
//  RD_LATENCY  2   read wait cycles, legal range 1..4
// PORTS
//  clock_i        in   1          clock, all logic on rising edge
//  reset_i        in   1          synchronous, active-low reset
//  en_pipeline_i  in   1          pipeline enable; low = no acceptance, WAIT countdown frozen
//  req_valid_i    in   1          request present this cycle
//  mem_read_i     in   1          load request
//  mem_write_i    in   1          store request
//  size_i         in   2          00 byte, 01 half, 10/11 word
//  unsigned_i     in   1          1 = zero-extend loads, 0 = sign-extend
//  addr_i         in   NB_ADDR    byte address (ALU result)
//  data_wr_i      in   NB_DATA    store data, right-aligned
//  data_rd_o      out  NB_DATA    load result, extended
//  rd_valid_o     out  1          one-cycle pulse, data_rd_o valid
//  busy_o         out  1          stall request to the hazard unit
//  misalign_o     out  1          one-cycle pulse, request rejected
//  dbg_addr_i     in   NB_ADDR-2  debug word index
//  dbg_data_o     out  NB_DATA    debug word, 1-cycle latency
// BEHAVIOUR
//  - Reset (reset_i=0 at edge): state IDLE; data_rd_o, rd_valid_o, busy_o, misalign_o, dbg_data_o = 0.
//    Array contents are not cleared. A read in progress is aborted with no rd_valid_o.
//  - FSM IDLE/WAIT.
//    Accept condition: IDLE & req_valid_i & en_pipeline_i.
//  - Illegal request (no access, misalign_o=1 next cycle):
//    half with addr_i[0]=1; word with addr_i[1:0]!=0; mem_read_i & mem_write_i both set.
//  - Store, accepted at cycle T: array written at end of T via byte enables, no RMW.
//    byte -> lane addr_i[1:0] gets data_wr_i[7:0]; half -> lanes {addr_i[1],x} get data_wr_i[15:0].
//    No busy_o; next request may be accepted at T+1.
//  - Load, accepted at T: goes to WAIT and latches addr, size, unsigned.
//    busy_o=1 in cycles T+1..T+RD_LATENCY (counter decrements only while en_pipeline_i=1).
//    Last WAIT cycle -> IDLE. At T+RD_LATENCY+1: rd_valid_o=1, data_rd_o valid, busy_o=0.
//    data_rd_o holds until the next load completes.
//  - Extraction: byte = word[8*a[1:0]+:8]; half = word[16*a[1]+:16]; extend per unsigned_i.
//  - Requests while in WAIT are ignored; upstream holds them because of busy_o.
//  - Word index = addr_i[NB_ADDR-1:2]. No out-of-range case exists; addresses wrap by truncation.
//  - Debug port: dbg_data_o <= mem[dbg_addr_i] every cycle.
//    Independent of the FSM; a same-cycle store is visible on the following read (read-first).
//  - Store to address X at cycle T followed by load of X: load returns the new data.
// TESTING
//  1 reset_i=0 during WAIT -> next cycle busy_o=0, rd_valid_o=0, data_rd_o=0; no later rd_valid_o.
//  2 sw 0x8899AABB @0x10, lb @0x11 signed -> after RD_LATENCY+1 cycles data_rd_o=0xFFFFFFAA, rd_valid_o 1 cycle.
//  3 sb 0x7F @0x12 over 0x8899AABB, then lhu @0x12 -> 0x0000997F? no: word 0x887FAABB -> lhu @0x12 = 0x0000887F.
//  4 lw @0x06 -> misalign_o=1 one cycle, busy_o=0, memory unchanged (dbg word 1 unchanged).
//  5 lw with en_pipeline_i dropped 3 cycles in WAIT -> busy_o stretched by 3; data still correct.
//  6 read+write both set @0x20 -> misalign_o=1, mem[8] unchanged; dbg_addr_i=8 reads old value.

Source files
------------

// File: rtl/data_mem_unit.sv
// MEM-stage data memory: byte/half/word access, multi-cycle reads.
// Illegal requests are flagged; side debug read port for the debug unit.
module data_mem_unit #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               en_pipeline_i,
  input  logic               req_valid_i,
  input  logic               mem_read_i,
  input  logic               mem_write_i,
  input  logic [1:0]         size_i,
  input  logic               unsigned_i,
  input  logic [NB_ADDR-1:0] addr_i,
  input  logic [NB_DATA-1:0] data_wr_i,
  output logic [NB_DATA-1:0] data_rd_o,
  output logic               rd_valid_o,
  output logic               busy_o,
  output logic               misalign_o,
  input  logic [NB_ADDR-3:0] dbg_addr_i,
  output logic [NB_DATA-1:0] dbg_data_o
);

  localparam int NB_LANE = NB_DATA / 8;
  localparam int DEPTH   = 2 ** (NB_ADDR - 2);

  typedef enum logic {IDLE, WAIT} state_t;

  logic [NB_DATA-1:0] mem_q [DEPTH];

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [NB_DATA-1:0] data_rd_q, data_rd_d;
  logic               rd_valid_q, rd_valid_d;
  logic               misalign_q, misalign_d;
  logic [NB_DATA-1:0] dbg_data_q;

  logic               accept;
  logic               illegal;
  logic               do_wr;
  logic               do_rd;
  logic [NB_LANE-1:0] wr_be;
  logic [NB_DATA-1:0] wr_data;
  logic [NB_DATA-1:0] rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [NB_DATA-1:0] rd_ext;

  // Request decode: acceptance, legality and store lane enables.
  always_comb begin
    accept  = (state_q == IDLE) & req_valid_i & en_pipeline_i;
    illegal = (mem_read_i & mem_write_i)
            | ((mem_read_i | mem_write_i)
               & (((size_i == 2'b01) & addr_i[0])
                  | (size_i[1] & (|addr_i[1:0]))));
    do_wr   = accept & mem_write_i & ~illegal;
    do_rd   = accept & mem_read_i & ~illegal;
    wr_be   = '0;
    wr_data = data_wr_i;
    unique case (1'b1)
      size_i[1]: begin
        wr_be   = '1;
        wr_data = data_wr_i;
      end
      (size_i == 2'b01): begin
        wr_be   = NB_LANE'(2'b11) << {addr_i[1], 1'b0};
        wr_data = {(NB_DATA/16){data_wr_i[15:0]}};
      end
      (size_i == 2'b00): begin
        wr_be   = NB_LANE'(1'b1) << addr_i[1:0];
        wr_data = {(NB_DATA/8){data_wr_i[7:0]}};
      end
    endcase
  end

  // Load lane extraction from the latched request.
  always_comb begin
    rd_word = mem_q[addr_q[NB_ADDR-1:2]];
    rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    rd_half = rd_word[{addr_q[1], 4'b0000} +: 16];
    rd_ext  = rd_word;
    unique case (1'b1)
      size_q[1]:
        rd_ext = rd_word;
      (size_q == 2'b01):
        rd_ext = {{(NB_DATA-16){~uns_q & rd_half[15]}}, rd_half};
      (size_q == 2'b00):
        rd_ext = {{(NB_DATA-8){~uns_q & rd_byte[7]}}, rd_byte};
    endcase
  end

  // Next-state logic for the IDLE/WAIT read sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    data_rd_d  = data_rd_q;
    rd_valid_d = 1'b0;
    misalign_d = accept & illegal;
    unique case (state_q)
      IDLE: begin
        if (do_rd) begin
          state_d = WAIT;
          cnt_d   = 3'(RD_LATENCY);
          addr_d  = addr_i;
          size_d  = size_i;
          uns_d   = unsigned_i;
        end
      end
      WAIT: begin
        if (en_pipeline_i) begin
          if (cnt_q == 3'd1) begin
            state_d    = IDLE;
            rd_valid_d = 1'b1;
            data_rd_d  = rd_ext;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      data_rd_q  <= '0;
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      data_rd_q  <= data_rd_d;
      rd_valid_q <= rd_valid_d;
      misalign_q <= misalign_d;
    end
  end

  // Byte-enabled array write; contents survive reset.
  always_ff @(posedge clock_i) begin
    if (reset_i && do_wr) begin
      for (int l = 0; l < NB_LANE; l++) begin
        if (wr_be[l]) begin
          mem_q[addr_i[NB_ADDR-1:2]][8*l +: 8] <= wr_data[8*l +: 8];
        end
      end
    end
  end

  // Debug read, read-first against a same-cycle store.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      dbg_data_q <= '0;
    end else begin
      dbg_data_q <= mem_q[dbg_addr_i];
    end
  end

  assign data_rd_o  = data_rd_q;
  assign rd_valid_o = rd_valid_q;
  assign misalign_o = misalign_q;
  assign busy_o     = (state_q == WAIT);
  assign dbg_data_o = dbg_data_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed table, corner sequences,
// random traffic against a byte-addressed reference memory.
module tb_data_mem_unit;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        en_pipeline_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [1:0]  size_i = 2'b10;
  logic        unsigned_i = 1'b0;
  logic [9:0]  addr_i = '0;
  logic [31:0] data_wr_i = '0;
  logic [31:0] data_rd_o;
  logic        rd_valid_o;
  logic        busy_o;
  logic        misalign_o;
  logic [7:0]  dbg_addr_i = '0;
  logic [31:0] dbg_data_o;

  always #5 clk = ~clk;

  data_mem_unit #(
    .NB_DATA(32), .NB_ADDR(10), .RD_LATENCY(L)
  ) dut (
    .clock_i(clk), .reset_i(reset_i),
    .en_pipeline_i(en_pipeline_i),
    .req_valid_i(req_valid_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .size_i(size_i), .unsigned_i(unsigned_i),
    .addr_i(addr_i), .data_wr_i(data_wr_i),
    .data_rd_o(data_rd_o), .rd_valid_o(rd_valid_o),
    .busy_o(busy_o), .misalign_o(misalign_o),
    .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mem_m [1024];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [9:0]  a;
    logic [31:0] wd;
    logic        mis;
    logic [31:0] exp;
  } vec_t;

  vec_t vec [20];
  int   nvec;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mword(int i);
    return {mem_m[4*i+3], mem_m[4*i+2], mem_m[4*i+1], mem_m[4*i]};
  endfunction

  function automatic logic [31:0] mload(logic [1:0] sz, logic uns,
                                        logic [9:0] a);
    int b;
    logic [15:0] h;
    logic [7:0] y;
    b = int'(a);
    if (sz[1]) return mword(b / 4);
    if (sz == 2'b01) begin
      h = {mem_m[b+1], mem_m[b]};
      return uns ? {16'h0, h} : {{16{h[15]}}, h};
    end
    y = mem_m[b];
    return uns ? {24'h0, y} : {{24{y[7]}}, y};
  endfunction

  task automatic mstore(logic [1:0] sz, logic [9:0] a, logic [31:0] wd);
    int b;
    int n;
    b = int'(a);
    n = sz[1] ? 4 : (sz == 2'b01 ? 2 : 1);
    for (int k = 0; k < n; k++) mem_m[b+k] = wd[8*k +: 8];
  endtask

  task automatic chk_dbg(int i);
    dbg_addr_i = 8'(i);
    step;
    chk("dbg_word", dbg_data_o, mword(i));
  endtask

  task automatic issue(input logic rd, input logic wr,
                       input logic [1:0] sz, input logic uns,
                       input logic [9:0] a, input logic [31:0] wd,
                       input int stall, input bit junk,
                       output logic [31:0] got, output logic mis);
    logic ill;
    logic [31:0] exp;
    int nb;
    ill = (rd && wr) || ((rd || wr) &&
          ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00)));
    exp = mload(sz, uns, a);
    mem_read_i = rd; mem_write_i = wr; size_i = sz;
    unsigned_i = uns; addr_i = a; data_wr_i = wd;
    req_valid_i = 1'b1; en_pipeline_i = 1'b1;
    step;
    req_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    got = data_rd_o;
    mis = misalign_o;
    if (ill) begin
      chk("illegal_pulse", misalign_o, 1);
      chk("illegal_busy", busy_o, 0);
      step;
      chk("illegal_clear", misalign_o, 0);
    end else if (wr) begin
      mstore(sz, a, wd);
      chk("store_misalign", misalign_o, 0);
      chk("store_busy", busy_o, 0);
    end else if (rd) begin
      chk("load_misalign", misalign_o, 0);
      nb = 0;
      while (busy_o && nb < 40) begin
        en_pipeline_i = !(nb >= 1 && nb < 1 + stall);
        if (junk) begin
          req_valid_i = 1'b1; mem_write_i = 1'b1; size_i = 2'b10;
          addr_i = 10'($urandom_range(0, 255)) << 2;
          data_wr_i = $urandom;
        end
        step;
        nb++;
      end
      req_valid_i = 1'b0; mem_write_i = 1'b0; en_pipeline_i = 1'b1;
      chk("load_busy_cycles", nb, L + stall);
      chk("load_valid", rd_valid_o, 1);
      chk("load_data", data_rd_o, exp);
      got = data_rd_o;
      step;
      chk("load_valid_pulse", rd_valid_o, 0);
      chk("load_data_hold", data_rd_o, exp);
    end else begin
      chk("noop_misalign", misalign_o, 0);
      chk("noop_busy", busy_o, 0);
    end
  endtask

  initial begin
    logic [31:0] got;
    logic mis;
    logic seen;
    logic [1:0] sz;
    logic [9:0] a;
    int r;

    vec[0]  = '{0, 1, 2'b10, 0, 10'h010, 32'h8899AABB, 0, 0};
    vec[1]  = '{1, 0, 2'b00, 0, 10'h011, 32'h0, 0, 32'hFFFFFFAA};
    vec[2]  = '{0, 1, 2'b00, 0, 10'h012, 32'hDEADBE7F, 0, 0};
    vec[3]  = '{1, 0, 2'b01, 1, 10'h012, 32'h0, 0, 32'h0000887F};
    vec[4]  = '{1, 0, 2'b01, 0, 10'h012, 32'h0, 0, 32'hFFFF887F};
    vec[5]  = '{1, 0, 2'b00, 1, 10'h013, 32'h0, 0, 32'h00000088};
    vec[6]  = '{1, 0, 2'b10, 0, 10'h010, 32'h0, 0, 32'h887FAABB};
    vec[7]  = '{1, 0, 2'b10, 0, 10'h006, 32'h0, 1, 0};
    vec[8]  = '{1, 1, 2'b10, 0, 10'h020, 32'h12345678, 1, 0};
    vec[9]  = '{0, 1, 2'b10, 0, 10'h014, 32'h00000000, 0, 0};
    vec[10] = '{0, 1, 2'b01, 0, 10'h016, 32'hFFFF1234, 0, 0};
    vec[11] = '{1, 0, 2'b11, 0, 10'h014, 32'h0, 0, 32'h12340000};
    vec[12] = '{1, 0, 2'b01, 0, 10'h016, 32'h0, 0, 32'h00001234};
    vec[13] = '{0, 1, 2'b01, 0, 10'h015, 32'h0000FFFF, 1, 0};
    vec[14] = '{0, 1, 2'b00, 0, 10'h014, 32'h00000080, 0, 0};
    vec[15] = '{1, 0, 2'b00, 0, 10'h014, 32'h0, 0, 32'hFFFFFF80};
    vec[16] = '{0, 1, 2'b10, 0, 10'h3FC, 32'hCAFEF00D, 0, 0};
    vec[17] = '{1, 0, 2'b01, 1, 10'h3FE, 32'h0, 0, 32'h0000CAFE};
    vec[18] = '{0, 1, 2'b10, 0, 10'h01A, 32'h11111111, 1, 0};
    vec[19] = '{1, 0, 2'b10, 0, 10'h014, 32'h0, 0, 32'h12340080};
    nvec = 20;

    step;
    step;
    chk("reset_data_rd", data_rd_o, 0);
    chk("reset_rd_valid", rd_valid_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_misalign", misalign_o, 0);
    chk("reset_dbg", dbg_data_o, 0);
    reset_i = 1'b1;
    step;

    for (int i = 0; i < 256; i++)
      issue(0, 1, 2'b10, 0, 10'(i * 4), $urandom, 0, 0, got, mis);

    for (int i = 0; i < nvec; i++) begin
      issue(vec[i].rd, vec[i].wr, vec[i].sz, vec[i].uns, vec[i].a,
            vec[i].wd, 0, 0, got, mis);
      chk($sformatf("vec%0d_misalign", i), mis, vec[i].mis);
      if (vec[i].rd && !vec[i].wr && !vec[i].mis)
        chk($sformatf("vec%0d_data", i), got, vec[i].exp);
      if (vec[i].mis) chk_dbg(int'(vec[i].a[9:2]));
    end

    issue(1, 0, 2'b10, 0, 10'h010, 0, 3, 0, got, mis);
    issue(1, 0, 2'b00, 1, 10'h011, 0, 3, 1, got, mis);
    chk("stall_data", got, 32'h000000AA);

    mem_read_i = 1'b1; size_i = 2'b10; addr_i = 10'h010;
    req_valid_i = 1'b1;
    step;
    req_valid_i = 1'b0; mem_read_i = 1'b0;
    chk("abort_busy_before", busy_o, 1);
    reset_i = 1'b0;
    step;
    reset_i = 1'b1;
    chk("abort_busy", busy_o, 0);
    chk("abort_rd_valid", rd_valid_o, 0);
    chk("abort_data", data_rd_o, 0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step;
      seen = seen | rd_valid_o | busy_o;
    end
    chk("abort_no_late_valid", seen, 0);

    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      a  = 10'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (sz[1]) a[1:0] = 2'b00;
        else if (sz == 2'b01) a[0] = 1'b0;
      end
      issue(r == 8 || (r >= 4 && r <= 7), r <= 3 || r == 8, sz,
            1'($urandom), a, $urandom, $urandom_range(0, 2),
            1'($urandom), got, mis);
      if (n % 10 == 0) chk_dbg($urandom_range(0, 255));
    end

    for (int i = 0; i < 256; i += 17) chk_dbg(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
